mod_counter_ce: RTL and testbench
=================================

// Module: mod_counter_ce
// PURPOSE
//  Parametrised clock-enabled modulo-N counter; successor to the plain wrap-at-2^N counter.
//  Counts 0..MODULUS-1 with wrap, loads with range clamping, and emits terminal-count and
//  carry outputs so instances cascade into sec/min/hour chains in the alarm-clock datapath.
//  Optional down-count mode supports countdown/snooze timers.
// PARAMETERS
//  WIDTH    6   counter width in bits
//  MODULUS  60  count range 0..MODULUS-1; legal range 2..2**WIDTH, else elaboration $error
// PORTS
//  clk    in   1      single clock, all state on posedge
//  rst_n  in   1      asynchronous, active-low reset
//  ce     in   1      clock enable; gates both load and count
//  ld     in   1      load d (effective only when ce=1)
//  d      in   WIDTH  load value
//  up_dn  in   1      1=count up, 0=count down (see CONFIGURATION)
//  q      out  WIDTH  current count, registered
//  tc     out  1      terminal count, combinational from q and direction
//  co     out  1      carry/borrow pulse for the next stage, combinational
//  err    out  1      load-out-of-range flag, registered, one cycle
// BEHAVIOUR
//  - Reset: rst_n=0 forces q=0 and err=0 immediately, with no clock needed; tc/co follow q.
//  - Priority at posedge: rst_n low > ce=0 (hold q, err<=0) > ld (load) > count.
//  - Up: q==MODULUS-1 -> 0, else q+1. Down: q==0 -> MODULUS-1, else q-1.
//  - Arithmetic is WIDTH bits; compare against MODULUS-1 before incrementing,
//    never rely on natural 2^WIDTH overflow; q never exceeds MODULUS-1.
//  - tc = up ? (q==MODULUS-1) : (q==0). co = ce & ~ld & tc.
//    co is high in the cycle whose edge wraps q, so a downstream ce=co advances on that edge.
//  - Load: d<=MODULUS-1 -> q<=d, err<=0. d>MODULUS-1 -> q<=MODULUS-1 (clamp), err<=1.
//  - err is high for exactly the cycle after a clamped load; any other enabled edge clears it.
//  - Latency: one clock from ce/ld/up_dn to q; tc/co have zero latency from q.
//  - up_dn change takes effect on the next enabled edge; no glitch state.
//  - Reset asserted mid-count: q=0 at once; first enabled edge after release counts from 0.
// CONFIGURATION
//  Macro MOD_COUNTER_DOWN_EN:
//  - defined: up_dn honoured as above.
//  - undefined: up_dn port kept but ignored; counter is up-only; the down decrement logic is
//    not synthesised; tc = (q==MODULUS-1).
// STRUCTURE
//  - Shared package clock_pkg: direction constants DIR_UP=1'b1 / DIR_DN=1'b0, and the standard
//    SEC/MIN/HR modulus constants (60, 60, 24) used at instantiation.
//  - One combinational sub-module, mod_step (WIDTH, MODULUS; in q, up_dn; out nxt, tc),
//    computes the wrapped next value. The top holds the register, load clamp, err and co gating.
// TESTING  (WIDTH=6, MODULUS=60 unless noted)
//  1 Reset, then ce=1 up for 61 clocks -> q 0..59 then 0,1; tc=co=1 only while q=59.
//  2 ce=0 for 5 clocks at q=17 with ld=1,d=3 -> q stays 17, co=0, err=0.
//  3 ld=1,ce=1,d=45 -> q=45, err=0. ld=1,d=63 -> q=59, err=1 for one cycle,
//    then 0 on the next enabled count.
//  4 MOD_COUNTER_DOWN_EN defined, up_dn=0 at q=1 -> q 0 then 59; tc/co high while q=0.
//    Macro undefined with up_dn=0 -> counts up.
//  5 rst_n pulled low between edges at q=33 -> q=0 before the next edge.
//    Release -> next enabled edge gives q=1.
//  6 Cascade: two instances (60 and 24), second.ce=first.co, 1440 clocks -> both return to 0
//    together; ld at q=59 gives co=0 and no downstream increment.

Source files
------------

// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared constants for the alarm-clock counter datapath
//
// Purpose: count-direction encodings and the standard time-unit moduli
//          used when instantiating mod_counter_ce stages.
// Ports:   none (package)
package clock_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int SEC_MODULUS = 60;
  localparam int MIN_MODULUS = 60;
  localparam int HR_MODULUS  = 24;

endpackage : clock_pkg

// File: rtl/mod_counter_ce_step.sv
// rtl/mod_counter_ce_step.sv - combinational wrapped next-value and terminal-count logic
//
// Purpose: given the current count, produce the next count with wrap at
//          0 / MODULUS-1 and the terminal-count flag for the active direction.
//          The down path exists only when MOD_COUNTER_DOWN_EN is defined;
//          otherwise up_dn is ignored and the stage counts up only.
// Ports:
//   q      in   WIDTH  current count
//   up_dn  in   1      1 = up, 0 = down (honoured only with MOD_COUNTER_DOWN_EN)
//   nxt    out  WIDTH  count after one step
//   tc     out  1      terminal count for the active direction
module mod_step
  import clock_pkg::*;
#(
  parameter int WIDTH   = 6,
  parameter int MODULUS = 60
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up_dn,
  output logic [WIDTH-1:0] nxt,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

  // Wrap is decided by explicit compare so non-power-of-two moduli never
  // depend on natural 2^WIDTH overflow.
  logic at_max;
  assign at_max = (q == MAXV);

`ifdef MOD_COUNTER_DOWN_EN
  logic at_zero;
  assign at_zero = (q == '0);

  always_comb begin
    nxt = q;
    tc  = 1'b0;
    if (up_dn == DIR_UP) begin
      nxt = at_max ? '0 : q + WIDTH'(1);
      tc  = at_max;
    end else begin
      nxt = at_zero ? MAXV : q - WIDTH'(1);
      tc  = at_zero;
    end
  end
`else
  // Up-only build: direction input is deliberately left unconnected.
  logic unused_up_dn;
  assign unused_up_dn = up_dn;

  always_comb begin
    nxt = at_max ? '0 : q + WIDTH'(1);
    tc  = at_max;
  end
`endif

endmodule : mod_step

// File: rtl/mod_counter_ce.sv
// rtl/mod_counter_ce.sv - clock-enabled modulo-N counter with clamped load and cascade carry
//
// Purpose: counts 0..MODULUS-1 with wrap, loads with range clamping and
//          flags clamped loads; tc/co let stages chain (sec -> min -> hr).
//          Down counting is available when MOD_COUNTER_DOWN_EN is defined.
// Ports:
//   clk    in   1      clock, all state on posedge
//   rst_n  in   1      asynchronous active-low reset
//   ce     in   1      clock enable, gates load and count
//   ld     in   1      load d (only when ce=1)
//   d      in   WIDTH  load value
//   up_dn  in   1      1 = up, 0 = down
//   q      out  WIDTH  registered count
//   tc     out  1      terminal count, combinational from q and direction
//   co     out  1      carry/borrow for the next stage (ce & ~ld & tc)
//   err    out  1      high for one cycle after a clamped load
module mod_counter_ce
  import clock_pkg::*;
#(
  parameter int WIDTH   = 6,
  parameter int MODULUS = SEC_MODULUS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             up_dn,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             co,
  output logic             err
);

  generate
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("mod_counter_ce: MODULUS must lie in 2..2**WIDTH");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] nxt;

  mod_step #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) u_step (
    .q    (q),
    .up_dn(up_dn),
    .nxt  (nxt),
    .tc   (tc)
  );

  // A load on the wrap edge replaces the wrap, so it must not ripple
  // into the next stage.
  assign co = ce & ~ld & tc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      err <= 1'b0;
    end else if (!ce) begin
      err <= 1'b0;
    end else if (ld) begin
      if (d > MAXV) begin
        q   <= MAXV;
        err <= 1'b1;
      end else begin
        q   <= d;
        err <= 1'b0;
      end
    end else begin
      q   <= nxt;
      err <= 1'b0;
    end
  end

endmodule : mod_counter_ce

// File: tb/tb_mod_counter_ce.sv
// tb/tb_mod_counter_ce.sv - scoreboard bench for mod_counter_ce
module tb_mod_counter_ce;
  import clock_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       ce, ld, up_dn;
  logic [5:0] d;
  logic [5:0] q;
  logic       tc, co, err;

  mod_counter_ce #(.WIDTH(6), .MODULUS(SEC_MODULUS)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .ld(ld), .d(d), .up_dn(up_dn),
    .q(q), .tc(tc), .co(co), .err(err)
  );

  logic       c_ce, c_ld;
  logic [5:0] c_d;
  logic [5:0] s_q;
  logic       s_tc, s_co, s_err;
  logic [4:0] h_q;
  logic       h_tc, h_co, h_err;

  mod_counter_ce #(.WIDTH(6), .MODULUS(SEC_MODULUS)) u_sec (
    .clk(clk), .rst_n(rst_n), .ce(c_ce), .ld(c_ld), .d(c_d), .up_dn(DIR_UP),
    .q(s_q), .tc(s_tc), .co(s_co), .err(s_err)
  );

  mod_counter_ce #(.WIDTH(5), .MODULUS(HR_MODULUS)) u_hr (
    .clk(clk), .rst_n(rst_n), .ce(s_co), .ld(1'b0), .d(5'd0), .up_dn(DIR_UP),
    .q(h_q), .tc(h_tc), .co(h_co), .err(h_err)
  );

  typedef struct {
    logic [5:0] q;
    logic       tc;
    logic       co;
    logic       err;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic tc_of(input logic [5:0] qv, input logic u);
`ifdef MOD_COUNTER_DOWN_EN
    return u ? (qv == 6'd59) : (qv == 6'd0);
`else
    return (qv == 6'd59);
`endif
  endfunction

  // One enabled/disabled edge; expected post-edge state goes to the scoreboard.
  task automatic step(input logic c, input logic l, input logic [5:0] dv, input logic u,
                      input logic [5:0] eq, input logic ee, input string nm);
    exp_t e;
    @(negedge clk);
    ce = c; ld = l; d = dv; up_dn = u;
    @(posedge clk);
    e.q    = eq;
    e.err  = ee;
    e.tc   = tc_of(eq, u);
    e.co   = c & ~l & e.tc;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) chk("drain", sb.size(), 0);
  endtask

  // Monitor: compares registered outputs shortly after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.name, " q"},   q,   e.q);
        chk({e.name, " tc"},  tc,  e.tc);
        chk({e.name, " co"},  co,  e.co);
        chk({e.name, " err"}, err, e.err);
      end
    end
  end

  initial begin
    rst_n = 1'b0; ce = 1'b0; ld = 1'b0; d = 6'd0; up_dn = DIR_UP;
    c_ce = 1'b0; c_ld = 1'b0; c_d = 6'd0;
    #1;
    chk("reset q", q, 0);
    chk("reset err", err, 0);
    chk("reset tc", tc, 0);
    chk("reset co", co, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full up wrap: 61 edges from 0 end at 1 via 59 -> 0.
    for (int i = 0; i < 61; i++)
      step(1'b1, 1'b0, 6'd0, DIR_UP, 6'((i + 1) % 60), 1'b0, "count");
    for (int i = 2; i <= 17; i++)
      step(1'b1, 1'b0, 6'd0, DIR_UP, 6'(i), 1'b0, "to17");

    // ce=0 overrides a pending load.
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, 6'd3, DIR_UP, 6'd17, 1'b0, "hold");

    // Loads: in range, clamped, boundary, err cleared by count and by ce=0.
    step(1'b1, 1'b1, 6'd45, DIR_UP, 6'd45, 1'b0, "ld45");
    step(1'b1, 1'b1, 6'd63, DIR_UP, 6'd59, 1'b1, "ld63");
    step(1'b1, 1'b0, 6'd0,  DIR_UP, 6'd0,  1'b0, "errclr");
    step(1'b1, 1'b1, 6'd59, DIR_UP, 6'd59, 1'b0, "ld59");
    step(1'b1, 1'b1, 6'd60, DIR_UP, 6'd59, 1'b1, "ld60");
    step(1'b0, 1'b0, 6'd0,  DIR_UP, 6'd59, 1'b0, "errce0");

    // Direction: down wraps 0 -> 59 when enabled, else up_dn is ignored.
    step(1'b1, 1'b1, 6'd1, DIR_DN, 6'd1, 1'b0, "ld1");
`ifdef MOD_COUNTER_DOWN_EN
    step(1'b1, 1'b0, 6'd0, DIR_DN, 6'd0,  1'b0, "dn0");
    step(1'b1, 1'b0, 6'd0, DIR_DN, 6'd59, 1'b0, "dn59");
    step(1'b1, 1'b0, 6'd0, DIR_DN, 6'd58, 1'b0, "dn58");
`else
    step(1'b1, 1'b0, 6'd0, DIR_DN, 6'd2, 1'b0, "uponly2");
    step(1'b1, 1'b0, 6'd0, DIR_DN, 6'd3, 1'b0, "uponly3");
`endif

    // Asynchronous reset between edges.
    step(1'b1, 1'b1, 6'd33, DIR_UP, 6'd33, 1'b0, "ld33");
    drain();
    @(negedge clk);
    ce = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async rst q", q, 0);
    chk("async rst co", co, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 6'd0, DIR_UP, 6'd1, 1'b0, "postrst");
    drain();
    @(negedge clk);
    ce = 1'b0;

    // Cascade 60 x 24: full day returns both to zero.
    c_ce = 1'b1;
    for (int i = 1; i <= 1440; i++) begin
      @(posedge clk);
      #1;
      if (i == 60) begin
        chk("casc sec@60", s_q, 0);
        chk("casc hr@60", h_q, 1);
      end
      if (i == 1439) begin
        chk("casc sec@1439", s_q, 59);
        chk("casc hr@1439", h_q, 23);
        chk("casc co@1439", s_co, 1);
      end
    end
    chk("casc sec end", s_q, 0);
    chk("casc hr end", h_q, 0);

    // Load on the wrap cycle suppresses the carry.
    for (int i = 0; i < 59; i++) @(posedge clk);
    @(negedge clk);
    chk("casc pre-ld sec", s_q, 59);
    c_ld = 1'b1; c_d = 6'd10;
    #1;
    chk("casc ld co", s_co, 0);
    @(posedge clk);
    #1;
    chk("casc ld sec", s_q, 10);
    chk("casc ld hr", h_q, 0);
    @(negedge clk);
    c_ld = 1'b0; c_ce = 1'b0;

    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mod_counter_ce
